// File: rtl/mult9x9_rr_scheduler_if.sv
// Handshake bundle between accelerator lanes / result consumer
// and the shared MULT9X9 round-robin scheduler.
interface mult9x9_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   REQ_VALID;
    logic [NREQ-1:0]   REQ_READY;
    logic [NREQ*9-1:0] REQ_A;
    logic [NREQ*9-1:0] REQ_B;
    logic              RES_VALID;
    logic              RES_READY;
    logic [17:0]       RES_Z;
    logic [IDW-1:0]    RES_ID;

    // Requester lanes plus result consumer
    modport master (
        output REQ_VALID, REQ_A, REQ_B, RES_READY,
        input  REQ_READY, RES_VALID, RES_Z, RES_ID
    );

    // Scheduler side
    modport slave (
        input  REQ_VALID, REQ_A, REQ_B, RES_READY,
        output REQ_READY, RES_VALID, RES_Z, RES_ID
    );
endinterface

// File: rtl/mult9x9_rr_scheduler.sv
// Round-robin sharing of one 9x9 unsigned multiplier among NREQ lanes.
// Two register stages (operands, product) returned with requester tag.
module mult9x9_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       FLUSH,
    mult9x9_rr_scheduler_if.slave      bus
);

    logic           v1;
    logic           v2;
    logic [8:0]     ra;
    logic [8:0]     rb;
    logic [IDW-1:0] id1;
    logic [IDW-1:0] id2;
    logic [17:0]    z2;
    logic [IDW-1:0] ptr;

    logic           adv1;
    logic           adv2;
    logic           found;
    logic           grant;
    logic [IDW-1:0] g;
    logic [IDW-1:0] ptr_nxt;
    logic [8:0]     a_sel;
    logic [8:0]     b_sel;
    logic [17:0]    z;
    logic [NREQ-1:0] rdy;

    // Stage advance: S2 moves when empty or drained, S1 when S2 moves or S1 empty
    always_comb begin
        adv2 = !v2 || bus.RES_READY;
        adv1 = adv2 || !v1;
    end

    // Round-robin pick: first valid at or above ptr, else lowest valid below it
    always_comb begin
        found = 1'b0;
        g     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.REQ_VALID[i] && (IDW'(i) >= ptr)) begin
                found = 1'b1;
                g     = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.REQ_VALID[i]) begin
                found = 1'b1;
                g     = IDW'(i);
            end
        end
    end

    // Grant qualification, one-hot ready, operand mux and pointer advance
    always_comb begin
        grant   = found && adv1 && !FLUSH && !RST;
        rdy     = '0;
        if (grant) begin
            rdy[g] = 1'b1;
        end
        ptr_nxt = (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
        a_sel   = bus.REQ_A[9*g +: 9];
        b_sel   = bus.REQ_B[9*g +: 9];
        z       = {9'd0, ra} * {9'd0, rb};
    end

    assign bus.REQ_READY = rdy;
    assign bus.RES_VALID = v2;
    assign bus.RES_Z     = z2;
    assign bus.RES_ID    = id2;

    // Operand stage and RR pointer; operands hold when no new grant
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1  <= 1'b0;
            ra  <= '0;
            rb  <= '0;
            id1 <= '0;
            ptr <= '0;
        end else if (FLUSH) begin
            v1  <= 1'b0;
            ra  <= '0;
            rb  <= '0;
            id1 <= '0;
            ptr <= '0;
        end else if (adv1) begin
            if (grant) begin
                v1  <= 1'b1;
                ra  <= a_sel;
                rb  <= b_sel;
                id1 <= g;
                ptr <= ptr_nxt;
            end else begin
                v1  <= 1'b0;
            end
        end
    end

    // Product stage, held under result backpressure
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v2  <= 1'b0;
            z2  <= '0;
            id2 <= '0;
        end else if (FLUSH) begin
            v2  <= 1'b0;
            z2  <= '0;
            id2 <= '0;
        end else if (adv2) begin
            v2  <= v1;
            z2  <= z;
            id2 <= id1;
        end
    end

endmodule

// File: tb/tb_mult9x9_rr_scheduler.sv
// Directed bench for the shared 9x9 multiplier scheduler.
// Linear stimulus, immediate assertions against hand-computed values.
module tb_mult9x9_rr_scheduler;

    logic CLK = 1'b0;
    logic RST;
    logic FLUSH;

    int n_assert = 0;
    int n_fail   = 0;
    int n        = 0;
    int pops     = 0;

    mult9x9_rr_scheduler_if #(.NREQ(4), .IDW(2)) bus ();

    mult9x9_rr_scheduler #(.NREQ(4), .IDW(2)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .FLUSH (FLUSH),
        .bus   (bus)
    );

    // Free-running clock
    initial forever #5 CLK = ~CLK;

    int exp_rdy3 [10] = '{1, 2, 4, 8, 1, 2, 4, 8, 0, 0};
    int exp_rv3  [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int exp_id3  [10] = '{0, 0, 0, 1, 2, 3, 0, 1, 2, 3};
    int exp_z3   [10] = '{0, 0, 20, 22, 24, 26, 20, 22, 24, 26};

    int exp_rdy4 [11] = '{4, 4, 0, 0, 0, 4, 4, 4, 0, 0, 0};
    int exp_rv4  [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int exp_z4   [11] = '{0, 0, 21, 21, 21, 21, 28, 35, 42, 49, 0};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic set_op(input int i, input logic [8:0] a,
                          input logic [8:0] b);
        bus.REQ_A[9*i +: 9] = a;
        bus.REQ_B[9*i +: 9] = b;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST           = 1'b1;
        FLUSH         = 1'b0;
        bus.REQ_VALID = 4'hF;
        bus.REQ_A     = '0;
        bus.REQ_B     = '0;
        bus.RES_READY = 1'b0;

        // T1: reset state, then async reset with full pipe
        #2;
        chk("rst_rv", 32'(bus.RES_VALID), 0);
        chk("rst_z", 32'(bus.RES_Z), 0);
        chk("rst_id", 32'(bus.RES_ID), 0);
        chk("rst_rdy", 32'(bus.REQ_READY), 0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        bus.REQ_VALID = 4'b0001;
        set_op(0, 9'd3, 9'd5);
        set_op(1, 9'd4, 9'd4);
        #1;
        chk("t1_rdy0", 32'(bus.REQ_READY), 32'h1);
        tick();
        bus.REQ_VALID = 4'b0010;
        tick();
        bus.REQ_VALID = 4'hF;
        #1;
        chk("t1_full_rdy", 32'(bus.REQ_READY), 0);
        chk("t1_full_rv", 32'(bus.RES_VALID), 1);
        chk("t1_full_z", 32'(bus.RES_Z), 15);
        #1;
        RST = 1'b1;
        #1;
        chk("t1_async_rv", 32'(bus.RES_VALID), 0);
        chk("t1_async_z", 32'(bus.RES_Z), 0);
        chk("t1_async_rdy", 32'(bus.REQ_READY), 0);
        #1;
        RST = 1'b0;
        bus.RES_READY = 1'b1;
        #1;
        chk("t1_restart", 32'(bus.REQ_READY), 32'h1);
        bus.REQ_VALID = 4'h0;
        tick();

        // T3: round-robin with all lanes valid for 8 grants
        for (int i = 0; i < 4; i++) set_op(i, 9'(10 + i), 9'd2);
        for (int c = 0; c < 10; c++) begin
            bus.REQ_VALID = (c < 8) ? 4'hF : 4'h0;
            #1;
            chk($sformatf("t3_rdy_%0d", c), 32'(bus.REQ_READY), exp_rdy3[c]);
            chk($sformatf("t3_rv_%0d", c), 32'(bus.RES_VALID), exp_rv3[c]);
            if (exp_rv3[c] != 0) begin
                chk($sformatf("t3_id_%0d", c), 32'(bus.RES_ID), exp_id3[c]);
                chk($sformatf("t3_z_%0d", c), 32'(bus.RES_Z), exp_z3[c]);
            end
            tick();
        end

        // T2: latency through both stages
        bus.REQ_VALID = 4'b0010;
        set_op(1, 9'd25, 9'd17);
        #1;
        chk("t2_rdy", 32'(bus.REQ_READY), 32'h2);
        tick();
        bus.REQ_VALID = 4'h0;
        #1;
        chk("t2_rv_e1", 32'(bus.RES_VALID), 0);
        tick();
        #1;
        chk("t2_rv_e2", 32'(bus.RES_VALID), 1);
        chk("t2_z", 32'(bus.RES_Z), 425);
        chk("t2_id", 32'(bus.RES_ID), 1);
        tick();
        #1;
        chk("t2_rv_e3", 32'(bus.RES_VALID), 0);

        // T4: five ops from lane 2 with a 3-cycle result stall
        n    = 0;
        pops = 0;
        for (int c = 0; c < 11; c++) begin
            bus.RES_READY = !(c >= 2 && c <= 4);
            bus.REQ_VALID = (n < 5) ? 4'b0100 : 4'h0;
            set_op(2, 9'(n + 3), 9'd7);
            #1;
            chk($sformatf("t4_rdy_%0d", c), 32'(bus.REQ_READY), exp_rdy4[c]);
            chk($sformatf("t4_rv_%0d", c), 32'(bus.RES_VALID), exp_rv4[c]);
            if (exp_rv4[c] != 0) begin
                chk($sformatf("t4_z_%0d", c), 32'(bus.RES_Z), exp_z4[c]);
                chk($sformatf("t4_id_%0d", c), 32'(bus.RES_ID), 2);
            end
            if (bus.REQ_READY[2]) n++;
            if (bus.RES_VALID && bus.RES_READY) pops++;
            tick();
        end
        chk("t4_sent", 32'(n), 5);
        chk("t4_pops", 32'(pops), 5);

        // T5: flush with two ops in flight
        bus.RES_READY = 1'b1;
        bus.REQ_VALID = 4'b0011;
        set_op(0, 9'd6, 9'd6);
        set_op(1, 9'd7, 9'd7);
        #1;
        chk("t5_rdy_a", 32'(bus.REQ_READY), 32'h1);
        tick();
        chk("t5_rdy_b", 32'(bus.REQ_READY), 32'h2);
        tick();
        FLUSH = 1'b1;
        bus.REQ_VALID = 4'hF;
        #1;
        chk("t5_flush_rdy", 32'(bus.REQ_READY), 0);
        chk("t5_flush_z", 32'(bus.RES_Z), 36);
        tick();
        FLUSH = 1'b0;
        #1;
        chk("t5_rv", 32'(bus.RES_VALID), 0);
        chk("t5_z", 32'(bus.RES_Z), 0);
        chk("t5_id", 32'(bus.RES_ID), 0);
        chk("t5_ptr0", 32'(bus.REQ_READY), 32'h1);
        bus.REQ_VALID = 4'h0;
        tick();
        chk("t5_rv_p1", 32'(bus.RES_VALID), 0);
        tick();
        chk("t5_rv_p2", 32'(bus.RES_VALID), 0);

        // T6: boundary operands, lane 3 re-granted back to back
        bus.REQ_VALID = 4'b1000;
        set_op(3, 9'h1FF, 9'h1FF);
        #1;
        chk("t6_rdy_a", 32'(bus.REQ_READY), 32'h8);
        tick();
        set_op(3, 9'h000, 9'h1FF);
        #1;
        chk("t6_rdy_b", 32'(bus.REQ_READY), 32'h8);
        tick();
        bus.REQ_VALID = 4'h0;
        #1;
        chk("t6_rv_max", 32'(bus.RES_VALID), 1);
        chk("t6_z_max", 32'(bus.RES_Z), 32'h3FC01);
        chk("t6_id_max", 32'(bus.RES_ID), 3);
        tick();
        chk("t6_rv_zero", 32'(bus.RES_VALID), 1);
        chk("t6_z_zero", 32'(bus.RES_Z), 0);
        chk("t6_id_zero", 32'(bus.RES_ID), 3);
        tick();
        chk("t6_rv_end", 32'(bus.RES_VALID), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
